// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares the single external SRAM port between NUM_REQ requesters (UART
//   loader, milestone 1, milestone 2, VGA reader). A winner owns the port for
//   a burst. While it owns the port, its address, we_n and write data are
//   registered onto the SRAM pins. Read data is steered back to the requester
//   that issued each read through a READ_LAT-deep tag pipeline.
//
// Ports
//   Clock_50, Reset      clock (rising edge) and asynchronous active-high reset
//   Req_I                per-requester burst request (level)
//   Addr_I/We_n_I/Wdata_I  flattened per-requester access fields (slice i = requester i)
//   Rr_mode_I            0 = fixed priority (index 0 highest), 1 = round robin
//   Grant_O, Busy_O      registered one-hot ownership and "any grant active"
//   Preempt_O            1-cycle pulse to an owner whose grant was forcibly removed
//   Rd_valid_O, Rdata_O  one-hot read-return owner and passthrough read data
//   SRAM_address, SRAM_write_data, SRAM_we_n  registered SRAM pins
//   SRAM_read_data       data returned by the SRAM controller
module sram_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 2,
  parameter int MAX_HOLD = 0
) (
  input  logic                      Clock_50,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        Req_I,
  input  logic [NUM_REQ*ADDR_W-1:0] Addr_I,
  input  logic [NUM_REQ-1:0]        We_n_I,
  input  logic [NUM_REQ*DATA_W-1:0] Wdata_I,
  input  logic                      Rr_mode_I,
  output logic [NUM_REQ-1:0]        Grant_O,
  output logic [NUM_REQ-1:0]        Preempt_O,
  output logic [NUM_REQ-1:0]        Rd_valid_O,
  output logic [DATA_W-1:0]         Rdata_O,
  output logic [ADDR_W-1:0]         SRAM_address,
  output logic [DATA_W-1:0]         SRAM_write_data,
  output logic                      SRAM_we_n,
  input  logic [DATA_W-1:0]         SRAM_read_data,
  output logic                      Busy_O
);

  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {S_ARB_IDLE, S_ARB_OWN} state_t;

  state_t               state, state_nxt;
  logic [ID_W-1:0]      owner, owner_nxt;
  logic [ID_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_cnt_nxt;
  logic [NUM_REQ-1:0]   grant_nxt, preempt_nxt, own_mask;
  logic [ADDR_W-1:0]    addr_nxt;
  logic [DATA_W-1:0]    wdata_nxt;
  logic                 we_n_nxt;
  logic                 push_vld;
  logic                 others_req;
  logic [ID_W-1:0]      winner;

  logic                 tag_vld [READ_LAT];
  logic [ID_W-1:0]      tag_id  [READ_LAT];

  // Lowest set index wins.
  function automatic logic [ID_W-1:0] pick_fixed(input logic [NUM_REQ-1:0] req);
    logic [ID_W-1:0] res;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) res = ID_W'(i);
    return res;
  endfunction

  // First set index searching upward from ptr+1 with wrap; scanning the
  // distances backwards leaves the nearest hit as the final assignment.
  function automatic logic [ID_W-1:0] pick_rr(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) res = idx;
    end
    return res;
  endfunction

  assign own_mask   = NUM_REQ'(1) << owner;
  assign others_req = |(Req_I & ~own_mask);
  assign winner     = Rr_mode_I ? pick_rr(Req_I, rr_ptr) : pick_fixed(Req_I);
  assign Rdata_O    = SRAM_read_data;

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    hold_cnt_nxt = hold_cnt;
    grant_nxt    = Grant_O;
    preempt_nxt  = '0;
    addr_nxt     = SRAM_address;
    wdata_nxt    = SRAM_write_data;
    we_n_nxt     = SRAM_we_n;
    push_vld     = 1'b0;
    unique case (state)
      S_ARB_IDLE: begin
        we_n_nxt = 1'b1;
        if (|Req_I) begin
          owner_nxt    = winner;
          grant_nxt    = NUM_REQ'(1) << winner;
          hold_cnt_nxt = '0;
          if (Rr_mode_I) rr_ptr_nxt = winner;
          state_nxt    = S_ARB_OWN;
        end
      end
      S_ARB_OWN: begin
        if (!Req_I[owner]) begin
          // Release has priority over any new request; that request is
          // arbitrated from idle after one gap cycle.
          grant_nxt = '0;
          we_n_nxt  = 1'b1;
          state_nxt = S_ARB_IDLE;
        end else if (MAX_HOLD > 0 && hold_cnt == HOLD_LAST && others_req) begin
          grant_nxt   = '0;
          preempt_nxt = own_mask;
          we_n_nxt    = 1'b1;
          state_nxt   = S_ARB_IDLE;
        end else begin
          addr_nxt  = Addr_I[owner*ADDR_W +: ADDR_W];
          wdata_nxt = Wdata_I[owner*DATA_W +: DATA_W];
          we_n_nxt  = We_n_I[owner];
          push_vld  = We_n_I[owner];
          // Saturate at the limit so a late competitor triggers release promptly.
          if (MAX_HOLD > 0 && hold_cnt != HOLD_LAST) hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = S_ARB_IDLE;
    endcase
  end

  // Arbitration state and SRAM pin registers
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state           <= S_ARB_IDLE;
      owner           <= '0;
      rr_ptr          <= '0;
      hold_cnt        <= '0;
      Grant_O         <= '0;
      Busy_O          <= 1'b0;
      Preempt_O       <= '0;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
    end else begin
      state           <= state_nxt;
      owner           <= owner_nxt;
      rr_ptr          <= rr_ptr_nxt;
      hold_cnt        <= hold_cnt_nxt;
      Grant_O         <= grant_nxt;
      Busy_O          <= |grant_nxt;
      Preempt_O       <= preempt_nxt;
      SRAM_address    <= addr_nxt;
      SRAM_write_data <= wdata_nxt;
      SRAM_we_n       <= we_n_nxt;
    end
  end

  // Read-tag pipeline: stage 0 is loaded together with the pins, the output
  // register adds the final cycle so Rd_valid_O lines up READ_LAT cycles
  // after the address is visible on SRAM_address.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_id[i]  <= '0;
      end
      Rd_valid_O <= '0;
    end else begin
      tag_vld[0] <= push_vld;
      tag_id[0]  <= owner;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      Rd_valid_O <= tag_vld[READ_LAT-1] ? (NUM_REQ'(1) << tag_id[READ_LAT-1]) : '0;
    end
  end

endmodule
